// File: rtl/pwm_avalon_slave.sv
// Avalon-MM PWM generator with double-buffered period/duty.
// Period and duty written over the bus sit in pending registers and are
// copied to the active registers at each wrap, or continuously while stopped,
// so a running waveform never sees a partial update.
module pwm_avalon_slave #(
  parameter int          CNT_WIDTH    = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  parameter int unsigned RESET_DUTY   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        pwm_out
);

  localparam logic [CNT_WIDTH-1:0] RST_P = CNT_WIDTH'(RESET_PERIOD);
  localparam logic [CNT_WIDTH-1:0] RST_D = CNT_WIDTH'(RESET_DUTY);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PERIOD = 2'd1;
  localparam logic [1:0] A_DUTY   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic [2:0]           ctrl;      // [0] EN, [1] INV, [2] IRQ_EN
  logic [CNT_WIDTH-1:0] p_pend;
  logic [CNT_WIDTH-1:0] d_pend;
  logic [CNT_WIDTH-1:0] p_act;
  logic [CNT_WIDTH-1:0] d_act;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 run;
  logic                 pend;
  logic [31:0]          rd_mux;

  logic wr_en;
  logic rd_en;
  logic wrap;
  logic pwm_raw;

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign wrap    = run && (cnt == p_act);
  assign pwm_raw = run && (cnt < d_act);

  // Bus-visible configuration registers; writes land in the pending copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= '0;
      p_pend <= RST_P;
      d_pend <= RST_D;
    end else if (wr_en) begin
      case (address)
        A_CTRL:   ctrl   <= writedata[2:0];
        A_PERIOD: p_pend <= writedata[CNT_WIDTH-1:0];
        A_DUTY:   d_pend <= writedata[CNT_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  // Counter, run state and active-register reload on wrap or while stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      p_act <= RST_P;
      d_act <= RST_D;
    end else begin
      run <= ctrl[0];
      if (!run || wrap) begin
        cnt   <= '0;
        p_act <= p_pend;
        d_act <= d_pend;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  // Period-end flag: a wrap in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
    end else if (wrap) begin
      pend <= 1'b1;
    end else if (wr_en && (address == A_STATUS) && writedata[0]) begin
      pend <= 1'b0;
    end
  end

  // Registered outputs: waveform with polarity select, and level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= 1'b0;
      irq     <= 1'b0;
    end else begin
      pwm_out <= pwm_raw ^ ctrl[1];
      irq     <= pend & ctrl[2];
    end
  end

  // Read mux; PERIOD/DUTY return the pending values, zero-extended.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL:   rd_mux[2:0] = ctrl;
      A_PERIOD: rd_mux[CNT_WIDTH-1:0] = p_pend;
      A_DUTY:   rd_mux[CNT_WIDTH-1:0] = d_pend;
      A_STATUS: rd_mux[1:0] = {run, pend};
      default:  rd_mux = '0;
    endcase
  end

  // Read data register: one cycle latency, holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

endmodule
